// File: rtl/gamepad_reader_pkg.sv
// gamepad_reader_pkg: SNES pad bit map, frame width and poll FSM states.
package gamepad_reader_pkg;
    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;
    localparam int ID_LSB     = 12;
    localparam int PAD_BITS   = 16;

    typedef enum logic [2:0] {IDLE, LATCH, BIT_HI, BIT_LO, COMMIT} pad_state_t;
endpackage

// File: rtl/gamepad_reader_if.sv
// gamepad_reader_if: serial pad wires; master is the poller, slave is the pad.
interface gamepad_reader_if;
    logic pad_latch;
    logic pad_clk;
    logic pad_data;
    modport master (output pad_latch, output pad_clk, input pad_data);
    modport slave  (input pad_latch, input pad_clk, output pad_data);
endinterface

// File: rtl/gamepad_reader_sync_2ff.sv
// sync_2ff: two-flop synchronizer; resets to 1 so an idle line reads as released.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], d_i};
    assign q_o = sync_q[1];
endmodule

// File: rtl/gamepad_reader.sv
// gamepad_reader: polls an SNES pad on each v_sync rise and commits decoded controls.
module gamepad_reader
    import gamepad_reader_pkg::*;
#(
    parameter int CLK_DIV = 150
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                v_sync_i,
    gamepad_reader_if.master    pad,
    output logic [11:0]         buttons_o,
    output logic                pad_present_o,
    output logic                move_left_o,
    output logic                move_right_o,
    output logic                fire_o,
    output logic                fire_press_o,
    output logic                busy_o
);
    localparam logic [9:0] DIV_M1 = 10'(CLK_DIV - 1);

    pad_state_t          state_q, state_d;
    logic [9:0]          cnt_q, cnt_d;
    logic [3:0]          idx_q, idx_d;
    logic [PAD_BITS-1:0] shift_q, shift_d;
    logic                vs_q, data_s;
    logic [11:0]         buttons_q;
    logic                present_q, left_q, right_q, fire_q, press_q;

    sync_2ff u_sync (.clk(clk), .rst_n(rst_n), .d_i(pad.pad_data), .q_o(data_s));

    wire       phase_done = (cnt_q == 10'd0);
    wire [9:0] cnt_step   = phase_done ? DIV_M1 : cnt_q - 10'd1;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            vs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            vs_q    <= v_sync_i;
        end

    // LATCH spans two phases, using idx_q[0] as the phase selector so the counter stays 10 bits
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: if (v_sync_i && !vs_q) begin
                state_d = LATCH;
                cnt_d   = DIV_M1;
                idx_d   = '0;
            end
            LATCH: begin
                cnt_d = cnt_step;
                if (phase_done) begin
                    state_d = idx_q[0] ? BIT_HI : LATCH;
                    idx_d   = idx_q[0] ? 4'd0 : 4'd1;
                end
            end
            BIT_HI: begin
                cnt_d = cnt_step;
                if (phase_done) begin
                    shift_d[idx_q] = ~data_s;
                    state_d = (idx_q == 4'd15) ? COMMIT : BIT_LO;
                end
            end
            BIT_LO: begin
                cnt_d = cnt_step;
                if (phase_done) begin
                    state_d = BIT_HI;
                    idx_d   = idx_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pad.pad_latch = (state_q == LATCH);
        pad.pad_clk   = (state_q != BIT_LO);
        busy_o        = (state_q != IDLE);
    end

    // A missing pad reads all-pressed through the pull-down, so the ID nibble gates every output
    wire        present = (shift_q[PAD_BITS-1:ID_LSB] == '0);
    wire [11:0] btn     = present ? shift_q[ID_LSB-1:0] : 12'h000;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            buttons_q <= '0;
            present_q <= 1'b0;
            left_q    <= 1'b0;
            right_q   <= 1'b0;
            fire_q    <= 1'b0;
            press_q   <= 1'b0;
        end else begin
            press_q <= 1'b0;
            if (state_q == COMMIT) begin
                buttons_q <= btn;
                present_q <= present;
                left_q    <= btn[BTN_LEFT] & ~btn[BTN_RIGHT];
                right_q   <= btn[BTN_RIGHT] & ~btn[BTN_LEFT];
                fire_q    <= btn[BTN_A];
                press_q   <= btn[BTN_A] & ~fire_q;
            end
        end

    assign buttons_o     = buttons_q;
    assign pad_present_o = present_q;
    assign move_left_o   = left_q;
    assign move_right_o  = right_q;
    assign fire_o        = fire_q;
    assign fire_press_o  = press_q;
endmodule

// File: tb/tb_gamepad_reader.sv
// tb_gamepad_reader: directed frames against a behavioural SNES pad, scoreboarded commits.
module tb_gamepad_reader;
    import gamepad_reader_pkg::*;

    typedef struct packed {
        logic [11:0] b;
        logic        p, l, r, f;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v_sync = 1'b0;
    logic [11:0] buttons;
    logic        present, left, right, fire, press, busy;
    logic [11:0] pressed = '0;
    bit          absent = 1'b0;
    bit          prev_fire = 1'b0;
    int          k = 0;
    int          total = 0;
    int          bad = 0;
    exp_t        sb[$];

    gamepad_reader_if ifc ();

    gamepad_reader #(.CLK_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .v_sync_i(v_sync), .pad(ifc),
        .buttons_o(buttons), .pad_present_o(present), .move_left_o(left),
        .move_right_o(right), .fire_o(fire), .fire_press_o(press), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Pad model: latch reloads the frame, each rising pad_clk presents the next bit (0 = pressed)
    always @(posedge ifc.pad_latch or posedge ifc.pad_clk)
        if (ifc.pad_latch) k = 0;
        else               k = k + 1;

    always_comb begin
        logic [15:0] word;
        word = {4'b0000, pressed};
        ifc.pad_data = absent ? 1'b0 : (k < 16 ? ~word[k[3:0]] : 1'b0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_latch"}, 32'(ifc.pad_latch), 0);
        chk({tag, "_pclk"}, 32'(ifc.pad_clk), 1);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_btn"}, 32'(buttons), 0);
        chk({tag, "_ctl"}, 32'({present, left, right, fire, press}), 0);
    endtask

    task automatic poll(input string tag, input logic [11:0] pr, input bit abs,
                        input int second_vs, input int abort_at);
        exp_t e;
        int   n, lat, low, fall, idle_busy;
        logic pc_prev;
        pressed = pr;
        absent  = abs;
        e.b = abs ? 12'h000 : pr;
        e.p = !abs;
        e.l = e.b[BTN_LEFT] & ~e.b[BTN_RIGHT];
        e.r = e.b[BTN_RIGHT] & ~e.b[BTN_LEFT];
        e.f = e.b[BTN_A];
        if (abort_at == 0) sb.push_back(e);
        @(negedge clk);
        v_sync = 1'b1;
        n = 0; lat = 0; low = 0; fall = 0; pc_prev = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (n == 10) v_sync = 1'b0;
            if (second_vs != 0 && n == second_vs) v_sync = 1'b1;
            if (second_vs != 0 && n == second_vs + 10) v_sync = 1'b0;
            if (ifc.pad_latch) lat++;
            if (!ifc.pad_clk) low++;
            if (pc_prev && !ifc.pad_clk) fall++;
            pc_prev = ifc.pad_clk;
            if (abort_at != 0 && n == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_state({tag, "_abort"});
                prev_fire = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end while (busy && n < 400);
        chk({tag, "_latency"}, n, 134);
        chk({tag, "_latch_cycles"}, lat, 8);
        chk({tag, "_pclk_pulses"}, fall, 15);
        chk({tag, "_pclk_low"}, low, 60);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_buttons"}, 32'(buttons), 32'(e.b));
            chk({tag, "_present"}, 32'(present), 32'(e.p));
            chk({tag, "_moves"}, 32'({left, right}), 32'({e.l, e.r}));
            chk({tag, "_fire"}, 32'(fire), 32'(e.f));
            chk({tag, "_press"}, 32'(press), 32'(e.f & ~prev_fire));
            prev_fire = e.f;
        end
        @(negedge clk);
        chk({tag, "_press_width"}, 32'(press), 0);
        idle_busy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) idle_busy++;
        end
        chk({tag, "_stays_idle"}, idle_busy, 0);
    endtask

    initial begin
        int act;
        repeat (5) @(negedge clk);
        check_reset_state("reset_held");
        rst_n = 1'b1;
        act = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy || ifc.pad_latch || !ifc.pad_clk) act++;
        end
        chk("no_vsync_activity", act, 0);

        poll("left", 12'h040, 1'b0, 0, 0);
        poll("left_right", 12'h0C0, 1'b0, 0, 0);
        poll("absent", 12'h000, 1'b1, 0, 0);
        poll("mixed", 12'hA35, 1'b0, 0, 0);
        poll("a_f1", 12'h100, 1'b0, 0, 0);
        poll("a_f2", 12'h100, 1'b0, 0, 0);
        poll("a_f3", 12'h000, 1'b0, 0, 0);
        poll("right", 12'h080, 1'b0, 0, 0);
        poll("second_vs", 12'h040, 1'b0, 20, 0);
        poll("abort", 12'h140, 1'b0, 0, 70);
        poll("after_abort", 12'h900, 1'b0, 0, 0);

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
